wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, meaning entries per input FIFO; SHALL be a power of 2 and at least 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 a_valid, a_ready  input/output  1/1  port A handshake (pipeline writeback).
REQ-005 a_dest, a_data  input  5/32  port A destination register and value.
REQ-006 b_valid, b_ready  input/output  1/1  port B handshake (long-latency unit).
REQ-007 b_dest, b_data  input  5/32  port B destination register and value.
REQ-008 flush  input  1  discard all queued writes.
REQ-009 load  output  1  register-file write enable.
REQ-010 dest, in  output  5/32  register-file write address and data.
REQ-011 pending  output  32  bit r set while any queued or output-stage write targets r; bit 0 SHALL always be 0.

Function
REQ-012 A transfer on a port SHALL occur at a rising edge where valid and ready are both 1; {dest,data} SHALL be pushed into that port's FIFO.
REQ-013 x_ready SHALL be 1 when that FIFO holds fewer than DEPTH entries, computed from registered occupancy only; a full FIFO SHALL NOT accept a push in the same cycle it pops.
REQ-014 Each cycle the arbiter SHALL pop at most one entry, from FIFO A or FIFO B, into the registered output stage.
REQ-015 If only one FIFO is non-empty, that FIFO SHALL be popped.
REQ-016 If both are non-empty, the FIFO not granted last time SHALL be popped (round-robin); the pointer SHALL update only on a pop.
REQ-017 After reset the round-robin pointer SHALL favour port A.
REQ-018 Output stage: the cycle after a pop, load=1 and dest/in equal the popped entry; with no pop, load=0 and dest/in hold their previous values.
REQ-019 A popped entry with dest=0 SHALL be consumed, with load=0 in the following cycle and no register-file write.
REQ-020 Latency: an entry accepted at edge E into an empty FIFO, with no contention, SHALL drive load=1 in the cycle after edge E+1.
REQ-021 Writes from the same port SHALL reach the output in acceptance order; there is no ordering guarantee between ports.
REQ-022 Two writes to the same register SHALL both be issued in arbitration order; no merging.
REQ-023 flush=1 at an edge SHALL empty both FIFOs, discard any simultaneous push, suppress that edge's pop, and clear load; ready SHALL read 1 in the next cycle.
REQ-024 pending SHALL be a combinational OR over valid FIFO entries plus the output stage when load=1, with bit 0 masked.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH, with a separate count or extra pointer bit distinguishing full from empty.
REQ-026 Outputs are registered on posedge so the register file, which writes on negedge, captures them mid-cycle.

Reset
REQ-027 rst=1 SHALL clear both FIFO occupancies, load=0, dest=0, in=0, and set the round-robin pointer to A; FIFO storage need not be cleared.
REQ-028 rst SHALL take priority over flush, push, and pop, including in the middle of a backlog.
REQ-029 Reset outputs: a_ready=1 and b_ready=1 from the first cycle after reset deasserts; pending=0.

Structure
REQ-030 A shared package SHALL hold the wb_entry_t struct {dest[4:0], data[31:0]}, the reg-index width constant (5), and the data width constant (32).
REQ-031 One sub-module wb_fifo (parameter DEPTH; push/pop/full/empty plus entry visibility for pending) SHALL be instantiated twice.
REQ-032 Arbitration, the output register, and pending logic SHALL live in wb_arbiter.

Verification
REQ-033 After reset, A sends {dest=5, data=0xDEADBEEF} at edge 1 -> load=1, dest=5, in=0xDEADBEEF in the cycle after edge 2; pending[5]=1 from edge 1 until load drops.
REQ-034 A and B each queue 3 entries (A: x1-x3; B: x11-x13) in the same cycles -> output order x1, x11, x2, x12, x3, x13 with load continuously high.
REQ-035 B pushes 4 entries while the output is stalled because A is continuously full (DEPTH=4) -> b_ready=0 after the 4th; B is unblocked only by a pop; no entry is lost or duplicated.
REQ-036 A sends {dest=0, data=0x1234} -> it is consumed, load stays 0, pending stays 0.
REQ-037 Queue 2 entries per port, then assert flush together with a new A push -> the next cycle load=0, pending=0, both readies=1, and the flushed/new data never appear.
REQ-038 Assert rst with 3 entries queued -> the next cycle load=0, dest=0, in=0, pending=0; the first post-reset contention grants A.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths, writeback entry type and register one-hot helper.
package wb_arbiter_pkg;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 2 ** REG_W;
  typedef struct packed {
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
    return NREGS'(1) << r;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular writeback queue that also exposes which registers its live entries target.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  wb_entry_t        i_entry,
  output wb_entry_t        o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [NREGS-1:0] o_pend
);
  localparam int AW = $clog2(DEPTH);
  wb_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_head  = r_mem[r_rd];
  assign w_push  = push & ~o_full & ~flush;
  assign w_pop   = pop & ~o_empty & ~flush;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr  <= r_wr + AW'(w_push);
      r_rd  <= r_rd + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) if (w_push) r_mem[r_wr] <= i_entry;
  // a slot is live when its distance from the read pointer is below the occupancy
  always_comb begin
    o_pend = '0;
    for (int i = 0; i < DEPTH; i++)
      if ({1'b0, AW'(AW'(i) - r_rd)} < r_cnt) o_pend[r_mem[i].dest] = 1'b1;
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin merge of two writeback queues into one registered register-file write port.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [REG_W-1:0]  a_dest,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_W-1:0]  b_dest,
  input  logic [DATA_W-1:0] b_data,
  input  logic              flush,
  output logic              load,
  output logic [REG_W-1:0]  dest,
  output logic [DATA_W-1:0] in,
  output logic [NREGS-1:0]  pending
);
  wb_entry_t         w_a_head, w_b_head, w_head;
  logic              w_a_full, w_a_empty, w_b_full, w_b_empty;
  logic [NREGS-1:0]  w_a_pend, w_b_pend;
  logic              w_a_grant, w_b_grant, w_pop;
  logic              r_prio_b, r_load;
  logic [REG_W-1:0]  r_dest;
  logic [DATA_W-1:0] r_in;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk(clk), .rst(rst), .flush(flush), .push(a_valid), .pop(w_a_grant),
    .i_entry('{dest: a_dest, data: a_data}), .o_head(w_a_head),
    .o_full(w_a_full), .o_empty(w_a_empty), .o_pend(w_a_pend)
  );
  wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk(clk), .rst(rst), .flush(flush), .push(b_valid), .pop(w_b_grant),
    .i_entry('{dest: b_dest, data: b_data}), .o_head(w_b_head),
    .o_full(w_b_full), .o_empty(w_b_empty), .o_pend(w_b_pend)
  );
  assign a_ready   = ~w_a_full;
  assign b_ready   = ~w_b_full;
  // r_prio_b set means A won the last grant, so B goes first on the next contention
  assign w_a_grant = ~w_a_empty & (w_b_empty | ~r_prio_b);
  assign w_b_grant = ~w_b_empty & ~w_a_grant;
  assign w_pop     = (w_a_grant | w_b_grant) & ~flush;
  assign w_head    = w_a_grant ? w_a_head : w_b_head;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio_b <= 1'b0;
      r_load   <= 1'b0;
      r_dest   <= '0;
      r_in     <= '0;
    end else begin
      r_load <= w_pop && w_head.dest != '0;
      if (w_pop) begin
        r_prio_b <= w_a_grant;
        r_dest   <= w_head.dest;
        r_in     <= w_head.data;
      end
    end
  end
  assign load    = r_load;
  assign dest    = r_dest;
  assign in      = r_in;
  assign pending = (w_a_pend | w_b_pend | (r_load ? reg_onehot(r_dest) : '0)) & ~NREGS'(1);
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed checks of ordering, backpressure, flush and reset for wb_arbiter.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0, flush = 1'b0;
  logic [4:0]  a_dest = '0, b_dest = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, load;
  logic [4:0]  dest;
  logic [31:0] in;
  logic [31:0] pending;
  int total = 0, bad = 0;
  logic [36:0] qa[$], qb[$];
  wb_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_dest(a_dest), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_dest(b_dest), .b_data(b_data),
    .flush(flush), .load(load), .dest(dest), .in(in), .pending(pending)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; flush = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask
  task automatic mon();
    logic [36:0] e;
    if (load) begin
      if (in[31:28] == 4'hA) begin
        e = qa.size() != 0 ? qa.pop_front() : '1;
        chk("sb_a", {dest, in}, e);
      end else if (in[31:28] == 4'hB) begin
        e = qb.size() != 0 ? qb.pop_front() : '1;
        chk("sb_b", {dest, in}, e);
      end else chk("sb_tag", in[31:28], 4'hA);
    end
  endtask
  initial begin
    logic [4:0] ed [6];
    logic xa, xb;
    int ia, ib;
    ed = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13};
    do_reset();
    chk("rst_load", load, 0);
    chk("rst_dest", dest, 0);
    chk("rst_in", in, 0);
    chk("rst_pend", pending, 0);
    chk("rst_ardy", a_ready, 1);
    chk("rst_brdy", b_ready, 1);
    a_valid = 1; a_dest = 5; a_data = 32'hDEADBEEF;
    cyc();
    a_valid = 0;
    chk("lat_load0", load, 0);
    chk("lat_pend1", pending, 32'h20);
    cyc();
    chk("lat_load", load, 1);
    chk("lat_dest", dest, 5);
    chk("lat_in", in, 32'hDEADBEEF);
    chk("lat_pend2", pending, 32'h20);
    cyc();
    chk("lat_drop", load, 0);
    chk("lat_pend3", pending, 0);
    chk("lat_hold", dest, 5);
    do_reset();
    for (int k = 0; k < 8; k++) begin
      a_valid = k < 3; a_dest = 5'(k + 1); a_data = 32'hC0DE0000 + 32'(k + 1);
      b_valid = k < 3; b_dest = 5'(k + 11); b_data = 32'hC0DE0000 + 32'(k + 11);
      cyc();
      if (k >= 1 && k <= 6) begin
        chk("rr_load", load, 1);
        chk("rr_dest", dest, ed[k-1]);
        chk("rr_in", in, 32'hC0DE0000 + 32'(ed[k-1]));
      end else chk("rr_idle", load, 0);
    end
    a_valid = 0; b_valid = 0;
    do_reset();
    a_valid = 1; a_dest = 0; a_data = 32'h1234;
    cyc();
    a_valid = 0;
    chk("z_pend0", pending, 0);
    cyc();
    chk("z_load", load, 0);
    chk("z_pend", pending, 0);
    cyc();
    chk("z_load2", load, 0);
    do_reset();
    for (int k = 0; k < 2; k++) begin
      a_valid = 1; a_dest = 5'(k + 2); a_data = 32'hF100 + 32'(k);
      b_valid = 1; b_dest = 5'(k + 20); b_data = 32'hF200 + 32'(k);
      cyc();
    end
    chk("fl_pre_load", load, 1);
    flush = 1; a_valid = 1; a_dest = 9; a_data = 32'h999; b_valid = 0;
    cyc();
    flush = 0; a_valid = 0;
    chk("fl_load", load, 0);
    chk("fl_pend", pending, 0);
    chk("fl_ardy", a_ready, 1);
    chk("fl_brdy", b_ready, 1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("fl_gone", load, 0);
    end
    do_reset();
    a_valid = 1; a_dest = 7; a_data = 32'h77;
    b_valid = 1; b_dest = 8; b_data = 32'h88;
    cyc(); cyc();
    chk("mr_pre", dest, 7);
    rst = 1;
    cyc();
    rst = 0;
    chk("mr_load", load, 0);
    chk("mr_dest", dest, 0);
    chk("mr_in", in, 0);
    chk("mr_pend", pending, 0);
    chk("mr_ardy", a_ready, 1);
    chk("mr_brdy", b_ready, 1);
    cyc();
    chk("mr_idle", load, 0);
    cyc();
    a_valid = 0; b_valid = 0;
    chk("mr_grant_a", dest, 7);
    chk("mr_grant_in", in, 32'h77);
    do_reset();
    ia = 0; ib = 0;
    for (int k = 0; k < 8; k++) begin
      a_valid = 1; a_dest = 5'(ia + 1); a_data = 32'hA0000000 | 32'(ia);
      b_valid = 1; b_dest = 5'(ib + 16); b_data = 32'hB0000000 | 32'(ib);
      xa = a_ready; xb = b_ready;
      cyc();
      if (xa) begin qa.push_back({a_dest, a_data}); ia++; end
      if (xb) begin qb.push_back({b_dest, b_data}); ib++; end
      mon();
      if (k == 5) begin
        chk("bp_bfull", b_ready, 0);
        chk("bp_aopen", a_ready, 1);
      end
      if (k == 6) begin
        chk("bp_afull", a_ready, 0);
        chk("bp_bopen", b_ready, 1);
      end
    end
    a_valid = 0; b_valid = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      mon();
    end
    chk("bp_a_left", qa.size(), 0);
    chk("bp_b_left", qb.size(), 0);
    chk("bp_pend", pending, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
